press_config_ctrl: RTL and testbench
====================================

Name: press_config_ctrl

Overview:
Configuration sequencer that sits downstream of the push-button press classifier. It consumes that block's single-cycle short-press and long-press events and walks the user through a select-field / edit-value / commit flow. Each committed field/value pair is delivered to the configurable datapath over a valid/ready write port. A per-field shadow copy of the last committed values is kept so that editing starts from the current setting.

Parameters:
NUM_FIELDS, 4, number of configurable fields; field index width FW = $clog2(NUM_FIELDS), minimum 1
VAL_W, 4, width of a field value
FIELD_MAX, 9, largest legal value; edit values wrap from FIELD_MAX to 0; must be < 2**VAL_W
TIMEOUT_CYC, 50000, idle cycles in SELECT/EDIT before abandoning the edit; must be >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
short_press  in  1  one-cycle pulse from the press classifier: short press
long_press  in  1  one-cycle pulse from the press classifier: long press
cfg_ready  in  1  datapath accepts a write this cycle
cfg_valid  out  1  write request to the datapath
cfg_field  out  FW  field index of the write, or of the current selection
cfg_value  out  VAL_W  value being edited or written
mode  out  2  user-visible mode code: 0 IDLE, 1 SELECT, 2 EDIT, 3 COMMIT
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state IDLE; cfg_valid 0; cfg_field 0; cfg_value 0; mode 0; busy 0.
  - All shadow registers 0; timeout counter 0.
- Registered outputs: every output is a register or decodes only from the state/field/value registers. No combinational path exists from any input to any output.
- Event priority: if short_press and long_press are high in the same cycle, long_press wins and short_press is dropped.
- IDLE:
  - long_press -> SELECT, with field <= 0.
  - short_press is ignored.
- SELECT:
  - short_press -> field <= field+1, wrapping NUM_FIELDS-1 -> 0.
  - long_press -> EDIT, with value <= shadow[field].
- EDIT:
  - short_press -> value <= (value == FIELD_MAX) ? 0 : value+1.
  - long_press -> COMMIT.
- COMMIT:
  - cfg_valid = 1; cfg_field and cfg_value are held stable.
  - Both press inputs are ignored.
  - On a cycle where cfg_valid && cfg_ready: shadow[field] <= value, and the next state is IDLE, so cfg_valid is 0 in the following cycle.
  - Exactly one write is issued per commit.
  - With no timeout in COMMIT, the block waits indefinitely for cfg_ready.
- Latency:
  - A press event takes effect on the next rising edge, with mode updated in the same cycle as the state.
  - cfg_valid asserts 1 cycle after the long_press that ends EDIT.
- Timeout:
  - The counter clears on any accepted press and on every state change. It increments each cycle in SELECT/EDIT.
  - When it reaches TIMEOUT_CYC-1 with no press in that cycle -> IDLE. The edit value is discarded and the shadow is unchanged.
  - A press arriving in the expiry cycle wins over the timeout.
  - The counter is held at 0 in IDLE and COMMIT.
- cfg_value output:
  - In EDIT/COMMIT: the working value.
  - In SELECT: shadow[field], as a preview.
  - In IDLE: 0.
- Outside COMMIT, cfg_field shows the current selection (0 in IDLE).
- Reset mid-operation: returns to IDLE, clears shadows and drops cfg_valid on the next edge, regardless of cfg_ready.
- Illegal state encoding -> IDLE on the next edge.

Decomposition:
- Shared package press_cfg_pkg holds:
  - state enum cfg_state_t {IDLE, SELECT, EDIT, COMMIT}, 2-bit, with the encoding equal to the mode codes;
  - constants MODE_IDLE .. MODE_COMMIT.
- One natural sub-module: press_timeout_timer (parameter TIMEOUT_CYC; ports clk, rst, clear, enable; output expired).
- Shadow registers, field/value registers and the FSM stay in the top module.

Test Plan:
- Reset then idle: after rst, hold rst low for 10 cycles with no presses -> mode=0, busy=0, cfg_valid=0. A short_press in IDLE -> no change.
- Full commit:
  - Stimulus: long, short, short (field 2), long, 3 shorts, long; cfg_ready tied 1.
  - Required: a single cfg_valid cycle with field=2, value=3; then mode=0. A following long, 2 shorts, long shows value=3 as the EDIT start.
- Wrap-around:
  - Stimulus: in SELECT, 4 shorts with NUM_FIELDS=4.
  - Required: field returns to 0.
  - Stimulus: in EDIT from 0, 10 shorts with FIELD_MAX=9.
  - Required: value returns to 0.
- Backpressure:
  - Stimulus: in COMMIT, hold cfg_ready=0 for 7 cycles with short/long pulses injected, then raise it.
  - Required: cfg_valid=1 with field/value stable for all 7 cycles; the write is accepted on cfg_ready; exactly one write; presses had no effect.
- Timeout (TIMEOUT_CYC=20):
  - Stimulus: enter EDIT, 2 shorts, then no input.
  - Required: mode=0 20 cycles after the last press; no cfg_valid; shadow unchanged.
  - Stimulus: repeat with a short at the expiry cycle.
  - Required: stays in EDIT with value incremented.
- Simultaneous and reset:
  - Stimulus: short and long in the same cycle in SELECT.
  - Required: goes to EDIT; field unchanged.
  - Stimulus: rst asserted during COMMIT with cfg_ready=0.
  - Required: cfg_valid=0 and mode=0 after the edge; all shadows 0.

Source files
------------

// File: rtl/press_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : press_cfg_pkg
// Description : Shared state encoding and mode codes for press_config_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package press_cfg_pkg;

    // State encoding doubles as the user-visible mode code.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EDIT   = 2'd2,
        COMMIT = 2'd3
    } cfg_state_t;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_SELECT = 2'd1;
    localparam logic [1:0] MODE_EDIT   = 2'd2;
    localparam logic [1:0] MODE_COMMIT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/press_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module      : press_timeout_timer
// Description : Idle-cycle counter; expired flags the TIMEOUT_CYC-th idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module press_timeout_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] r_count;

    assign expired = enable && (r_count == CW'(TIMEOUT_CYC - 1));

    // Expiry forces a state change upstream, so the count restarts there too.
    always_ff @(posedge clk) begin
        if (rst || clear || !enable || expired) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/press_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : press_config_ctrl
// Description : Select/edit/commit sequencer driven by short/long press events.
// Revision    : 1.0 - initial release
// ============================================================================
module press_config_ctrl
    import press_cfg_pkg::*;
#(
    parameter int NUM_FIELDS  = 4,
    parameter int VAL_W       = 4,
    parameter int FIELD_MAX   = 9,
    parameter int TIMEOUT_CYC = 50000,
    localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             short_press,
    input  logic             long_press,
    input  logic             cfg_ready,
    output logic             cfg_valid,
    output logic [FW-1:0]    cfg_field,
    output logic [VAL_W-1:0] cfg_value,
    output logic [1:0]       mode,
    output logic             busy
);

    cfg_state_t       r_state;
    logic [FW-1:0]    r_field;
    logic [VAL_W-1:0] r_value;
    logic             r_valid;
    logic [VAL_W-1:0] r_shadow [NUM_FIELDS];

    logic w_short;
    logic w_timer_en;
    logic w_press_acc;
    logic w_expired;

    // long_press takes priority when both pulses coincide.
    assign w_short     = short_press && !long_press;
    assign w_timer_en  = (r_state == SELECT) || (r_state == EDIT);
    assign w_press_acc = w_timer_en && (short_press || long_press);

    press_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_press_acc),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_field <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (long_press) begin
                        r_state <= SELECT;
                        r_field <= '0;
                    end
                end
                SELECT: begin
                    if (long_press) begin
                        r_state <= EDIT;
                        r_value <= r_shadow[r_field];
                    end else if (w_short) begin
                        r_field <= (r_field == FW'(NUM_FIELDS - 1)) ? '0 : r_field + FW'(1);
                    end else if (w_expired) begin
                        r_state <= IDLE;
                    end
                end
                EDIT: begin
                    if (long_press) begin
                        r_state <= COMMIT;
                        r_valid <= 1'b1;
                    end else if (w_short) begin
                        r_value <= (r_value == VAL_W'(FIELD_MAX)) ? '0 : r_value + VAL_W'(1);
                    end else if (w_expired) begin
                        r_state <= IDLE;
                    end
                end
                COMMIT: begin
                    if (r_valid && cfg_ready) begin
                        r_shadow[r_field] <= r_value;
                        r_valid           <= 1'b0;
                        r_state           <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_valid = r_valid;
    assign mode      = r_state;
    assign busy      = (r_state != IDLE);
    assign cfg_field = (r_state == IDLE) ? '0 : r_field;

    always_comb begin
        cfg_value = '0;
        case (r_state)
            SELECT:        cfg_value = r_shadow[r_field];
            EDIT, COMMIT:  cfg_value = r_value;
            default:       cfg_value = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_press_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_press_config_ctrl
// Description : Scoreboard bench for press_config_ctrl with a short timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_press_config_ctrl;

    localparam int NUM_FIELDS  = 4;
    localparam int VAL_W       = 4;
    localparam int FIELD_MAX   = 9;
    localparam int TIMEOUT_CYC = 20;
    localparam int FW          = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             short_press = 1'b0;
    logic             long_press  = 1'b0;
    logic             cfg_ready   = 1'b1;
    logic             cfg_valid;
    logic [FW-1:0]    cfg_field;
    logic [VAL_W-1:0] cfg_value;
    logic [1:0]       mode;
    logic             busy;

    int n_vec    = 0;
    int n_err    = 0;
    int n_writes = 0;

    typedef struct packed {
        logic [FW-1:0]    field;
        logic [VAL_W-1:0] value;
    } wr_t;

    wr_t exp_q[$];

    press_config_ctrl #(
        .NUM_FIELDS  (NUM_FIELDS),
        .VAL_W       (VAL_W),
        .FIELD_MAX   (FIELD_MAX),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .short_press (short_press),
        .long_press  (long_press),
        .cfg_ready   (cfg_ready),
        .cfg_valid   (cfg_valid),
        .cfg_field   (cfg_field),
        .cfg_value   (cfg_value),
        .mode        (mode),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic s, input logic l);
        short_press = s;
        long_press  = l;
        tick();
        short_press = 1'b0;
        long_press  = 1'b0;
    endtask

    task automatic expect_write(input int f, input int v);
        wr_t w;
        w.field = FW'(f);
        w.value = VAL_W'(v);
        exp_q.push_back(w);
    endtask

    // Write monitor: every accepted write is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && cfg_valid && cfg_ready) begin
            wr_t w;
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("write_field", 32'(cfg_field), 32'(w.field));
                check("write_value", 32'(cfg_value), 32'(w.value));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        rst = 1'b0;
        check("rst_mode",  32'(mode), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_valid", 32'(cfg_valid), 0);
        check("rst_field", 32'(cfg_field), 0);
        check("rst_value", 32'(cfg_value), 0);
        tick(10);
        check("idle_mode", 32'(mode), 0);
        pulse(1, 0);
        check("idle_short_mode", 32'(mode), 0);
        check("idle_short_busy", 32'(busy), 0);

        // Full commit of field 2 = 3
        cfg_ready = 1'b1;
        pulse(0, 1);
        check("sel_mode", 32'(mode), 1);
        check("sel_busy", 32'(busy), 1);
        check("sel_field0", 32'(cfg_field), 0);
        pulse(1, 0);
        pulse(1, 0);
        check("sel_field2", 32'(cfg_field), 2);
        check("sel_preview", 32'(cfg_value), 0);
        pulse(0, 1);
        check("edit_mode", 32'(mode), 2);
        check("edit_start", 32'(cfg_value), 0);
        for (int i = 0; i < 3; i++) pulse(1, 0);
        check("edit_val3", 32'(cfg_value), 3);
        expect_write(2, 3);
        pulse(0, 1);
        check("commit_mode", 32'(mode), 3);
        check("commit_valid", 32'(cfg_valid), 1);
        tick();
        check("post_commit_mode", 32'(mode), 0);
        check("post_commit_valid", 32'(cfg_valid), 0);
        check("writes_1", n_writes, 1);

        // Editing field 2 again starts from the committed value
        pulse(0, 1);
        pulse(1, 0);
        pulse(1, 0);
        check("preview_f2", 32'(cfg_value), 3);
        pulse(0, 1);
        check("edit_from_shadow", 32'(cfg_value), 3);
        expect_write(2, 3);
        pulse(0, 1);
        tick();
        check("writes_2", n_writes, 2);

        // Field and value wrap-around
        pulse(0, 1);
        for (int i = 0; i < 4; i++) pulse(1, 0);
        check("field_wrap", 32'(cfg_field), 0);
        pulse(0, 1);
        for (int i = 0; i < 9; i++) pulse(1, 0);
        check("value_max", 32'(cfg_value), 9);
        pulse(1, 0);
        check("value_wrap", 32'(cfg_value), 0);
        pulse(1, 0);
        pulse(1, 0);

        // Backpressure with presses injected during COMMIT
        cfg_ready = 1'b0;
        expect_write(0, 2);
        pulse(0, 1);
        for (int i = 0; i < 7; i++) begin
            pulse(i[0], !i[0]);
            check("bp_valid", 32'(cfg_valid), 1);
            check("bp_mode",  32'(mode), 3);
            check("bp_field", 32'(cfg_field), 0);
            check("bp_value", 32'(cfg_value), 2);
        end
        check("bp_no_write", n_writes, 2);
        cfg_ready = 1'b1;
        tick();
        check("bp_done_mode", 32'(mode), 0);
        check("bp_done_valid", 32'(cfg_valid), 0);
        check("writes_3", n_writes, 3);

        // Timeout abandons the edit
        pulse(0, 1);
        pulse(1, 0);
        pulse(0, 1);
        pulse(1, 0);
        pulse(1, 0);
        check("to_val2", 32'(cfg_value), 2);
        tick(TIMEOUT_CYC - 1);
        check("to_before", 32'(mode), 2);
        tick();
        check("to_expired", 32'(mode), 0);
        check("to_valid", 32'(cfg_valid), 0);
        pulse(0, 1);
        pulse(1, 0);
        check("to_shadow", 32'(cfg_value), 0);

        // Press in the expiry cycle wins
        pulse(0, 1);
        pulse(1, 0);
        pulse(1, 0);
        tick(TIMEOUT_CYC - 1);
        pulse(1, 0);
        check("to_press_mode", 32'(mode), 2);
        check("to_press_value", 32'(cfg_value), 3);
        tick(TIMEOUT_CYC);
        check("to_again", 32'(mode), 0);

        // Simultaneous presses in SELECT
        pulse(0, 1);
        pulse(1, 0);
        pulse(1, 1);
        check("simul_mode", 32'(mode), 2);
        check("simul_field", 32'(cfg_field), 1);

        // Reset during stalled COMMIT
        pulse(1, 0);
        cfg_ready = 1'b0;
        pulse(0, 1);
        check("pre_rst_valid", 32'(cfg_valid), 1);
        rst = 1'b1;
        tick();
        check("rst_cm_valid", 32'(cfg_valid), 0);
        check("rst_cm_mode", 32'(mode), 0);
        rst = 1'b0;
        cfg_ready = 1'b1;
        pulse(0, 1);
        for (int f = 0; f < NUM_FIELDS; f++) begin
            check("rst_shadow", 32'(cfg_value), 0);
            pulse(1, 0);
        end
        tick(TIMEOUT_CYC);
        check("final_mode", 32'(mode), 0);
        check("queue_empty", exp_q.size(), 0);
        check("writes_final", n_writes, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
